// File: rtl/countdown_pkg.sv
// Shared types and defaults for the countdown FSM and its button conditioner.
package countdown_pkg;

  localparam int COUNT_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/countdown_fsm_if.sv
// CPU/button-facing signal bundle of the countdown FSM; count_reg feeds the LED/switch peripheral.
interface countdown_fsm_if #(
  parameter int COUNT_W = 16
);
  logic [COUNT_W-1:0] load_value;
  logic               load_valid;
  logic               start_btn;
  logic [COUNT_W-1:0] count_reg;
  logic               busy;
  logic               done;

  modport master (
    output load_value, load_valid, start_btn,
    input  count_reg, busy, done
  );

  modport slave (
    input  load_value, load_valid, start_btn,
    output count_reg, busy, done
  );
endinterface

// File: rtl/countdown_fsm_btn_conditioner.sv
// Start-button conditioning: 2-flop synchroniser, optional debouncer, rising-edge detect.
// Build with DEBOUNCE_EN defined to insert the DB_CYCLES stability filter.
module btn_conditioner #(
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic start_btn,
  output logic start_pulse
);

  if (DB_CYCLES < 1) begin : g_db_chk
    $error("DB_CYCLES must be >= 1");
  end

  logic [1:0] sync_pipe;  // [0] = s1, [1] = s2
  logic       lvl;
  logic       prev;       // s3

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_pipe <= '0;
    else     sync_pipe <= {sync_pipe[0], start_btn};
  end

`ifdef DEBOUNCE_EN
  localparam int DW = $clog2(DB_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DB_CYCLES - 1);

  logic [DW-1:0] db_cnt;
  logic          db;

  // Any cycle where s2 agrees with db is a bounce and restarts the stability count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt <= '0;
      db     <= 1'b0;
    end else if (sync_pipe[1] != db) begin
      if (db_cnt == DB_LAST) begin
        db     <= sync_pipe[1];
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end else begin
      db_cnt <= '0;
    end
  end

  assign lvl = db;
`else
  assign lvl = sync_pipe[1];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev <= 1'b0;
    else     prev <= lvl;
  end

  assign start_pulse = lvl & ~prev;

endmodule

// File: rtl/countdown_fsm.sv
// Programmable down-counter: CPU preloads, button starts, decrements once per TICK_DIV clocks.
// DEBOUNCE_EN (optional) enables the start-button debouncer inside btn_conditioner.
module countdown_fsm
  import countdown_pkg::*;
#(
  parameter int COUNT_W   = COUNT_W_DEFAULT,
  parameter int TICK_DIV  = 100_000_000,
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic            clk,
  input  logic            rst,
  countdown_fsm_if.slave  bus
);

  if (TICK_DIV < 2) begin : g_div_chk
    $error("TICK_DIV must be >= 2");
  end

  localparam int TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  state_t             state, state_nx;
  logic [COUNT_W-1:0] cnt, cnt_nx;
  logic               busy_q, done_q;
  logic [TW-1:0]      tick_cnt;
  logic               tick;
  logic               start_pulse;

  btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_btn (
    .clk         (clk),
    .rst         (rst),
    .start_btn   (bus.start_btn),
    .start_pulse (start_pulse)
  );

  // Prescaler only runs in COUNT so every countdown starts from a fresh phase.
  assign tick = (state == COUNT) && (tick_cnt == TICK_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 tick_cnt <= '0;
    else if (state != COUNT) tick_cnt <= '0;
    else if (tick)           tick_cnt <= '0;
    else                     tick_cnt <= tick_cnt + 1'b1;
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        // A load in the same cycle as a start wins; the start is dropped.
        if (bus.load_valid)   cnt_nx   = bus.load_value;
        else if (start_pulse) state_nx = (cnt != '0) ? COUNT : DONE;
      end
      COUNT: begin
        if (tick) begin
          cnt_nx = cnt - 1'b1;
          if (cnt == COUNT_W'(1)) state_nx = DONE;
        end
      end
      DONE: begin
        if (bus.load_valid) begin
          cnt_nx   = bus.load_value;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      busy_q <= (state_nx == COUNT);
      done_q <= (state_nx == DONE);
    end
  end

  assign bus.count_reg = cnt;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_countdown_fsm.sv
// Self-checking bench for countdown_fsm: vector table, directed corner sequences, random vs model.
module tb_countdown_fsm;

  localparam int TICK_DIV  = 4;
  localparam int DB_CYCLES = 3;
`ifdef DEBOUNCE_EN
  localparam int LAT = DB_CYCLES + 2;
  localparam bit GLITCH_STARTS = 1'b0;
`else
  localparam int LAT = 2;
  localparam bit GLITCH_STARTS = 1'b1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  countdown_fsm_if #(.COUNT_W(16)) bus ();

  countdown_fsm #(.COUNT_W(16), .TICK_DIV(TICK_DIV), .DB_CYCLES(DB_CYCLES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input int c, input logic b, input logic d);
    check({name, ".count"}, bus.count_reg, c[15:0]);
    check({name, ".busy"},  bus.busy, b);
    check({name, ".done"},  bus.done, d);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load(input logic [15:0] v);
    bus.load_valid = 1'b1;
    bus.load_value = v;
    step(1);
    bus.load_valid = 1'b0;
  endtask

  typedef struct {
    logic        rst;
    logic        lv;
    logic [15:0] val;
    logic [15:0] ecnt;
    logic        ebusy;
    logic        edone;
  } vec_t;

  // Reference model: mode 0 idle, 1 counting, 2 finished; decrements fall on
  // every TICK_DIV-th cycle spent counting; the button acts LAT edges after a rising sample.
  int m_mode, m_cnt, m_cyc;
  bit hist[$];

  task automatic model_reset();
    m_mode = 0; m_cnt = 0; m_cyc = 0;
    hist.delete();
    for (int i = 0; i < LAT + 2; i++) hist.push_back(1'b0);
  endtask

  task automatic model_edge(input bit btn, input bit lv, input int val);
    bit start;
    hist.push_back(btn);
    void'(hist.pop_front());
    start = hist[1] & ~hist[0];
    case (m_mode)
      0: begin
        if (lv) m_cnt = val;
        else if (start) begin
          m_mode = (m_cnt != 0) ? 1 : 2;
          m_cyc  = 0;
        end
      end
      1: begin
        m_cyc++;
        if (m_cyc % TICK_DIV == 0) begin
          m_cnt--;
          if (m_cnt == 0) m_mode = 2;
        end
      end
      default: begin
        if (lv) begin
          m_cnt  = val;
          m_mode = 0;
        end
      end
    endcase
  endtask

  initial begin
    vec_t tbl[7];
    int   hold;

    bus.load_valid = 1'b0;
    bus.load_value = '0;
    bus.start_btn  = 1'b0;

    // Reset, loads, back-to-back loads, full-scale value; button idle.
    tbl[0] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 16'h0003, 16'h0003, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 16'h0009, 16'h0003, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 16'h0003, 16'h0003, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 16'h0000, 16'h0003, 1'b0, 1'b0};
    for (int i = 0; i < 7; i++) begin
      rst            = tbl[i].rst;
      bus.load_valid = tbl[i].lv;
      bus.load_value = tbl[i].val;
      step(1);
      chk_out($sformatf("vec%0d", i), tbl[i].ecnt, tbl[i].ebusy, tbl[i].edone);
    end
    bus.load_valid = 1'b0;

    // Countdown from 3, with a load attempt during COUNT that must be ignored.
    bus.start_btn = 1'b1;
    step(LAT);
    chk_out("start_pre", 3, 1'b0, 1'b0);
    step(1);
    chk_out("start_busy", 3, 1'b1, 1'b0);
    for (int e = 1; e <= 12; e++) begin
      bus.load_valid = (e == 1);
      bus.load_value = 16'd5;
      step(1);
      bus.load_valid = 1'b0;
      chk_out($sformatf("cd_e%0d", e), 3 - e / 4, e < 12, e == 12);
    end

    // Press in DONE has no effect; load 7 returns to IDLE.
    bus.start_btn = 1'b0;
    step(4);
    bus.start_btn = 1'b1;
    step(LAT + 4);
    chk_out("done_press", 0, 1'b0, 1'b1);
    bus.start_btn = 1'b0;
    step(LAT + 2);
    load(16'd7);
    chk_out("done_load", 7, 1'b0, 1'b0);
    step(3);
    chk_out("idle_hold", 7, 1'b0, 1'b0);

    // Load coinciding with the start pulse: load wins, start dropped.
    bus.start_btn = 1'b1;
    step(LAT);
    load(16'd5);
    chk_out("collide", 5, 1'b0, 1'b0);
    step(6);
    chk_out("collide_hold", 5, 1'b0, 1'b0);

    // Zero start goes straight to DONE without busy.
    bus.start_btn = 1'b0;
    step(LAT + 2);
    load(16'd0);
    bus.start_btn = 1'b1;
    for (int e = 1; e <= LAT + 3; e++) begin
      step(1);
      chk_out($sformatf("zero_e%0d", e), 0, 1'b0, e >= LAT + 1);
    end

    // Reset mid-count at count 2 clears outputs without waiting for an edge.
    load(16'd3);
    bus.start_btn = 1'b0;
    step(LAT + 2);
    bus.start_btn = 1'b1;
    step(LAT + 1);
    step(4);
    chk_out("pre_abort", 2, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1 chk_out("abort", 0, 1'b0, 1'b0);
    bus.start_btn = 1'b0;
    step(2);
    rst = 1'b0;
    step(1);
    chk_out("post_abort", 0, 1'b0, 1'b0);

    // Two-cycle glitch: starts the count only without the debouncer.
    load(16'd4);
    step(2);
    bus.start_btn = 1'b1;
    step(2);
    bus.start_btn = 1'b0;
    step(12);
    chk_out("glitch", 4 - (GLITCH_STARTS ? 2 : 0), GLITCH_STARTS, 1'b0);
    step(20);
    chk_out("glitch_end", GLITCH_STARTS ? 0 : 4, 1'b0, GLITCH_STARTS);

    // Randomized traffic against the reference model.
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    model_reset();
    hold = $urandom_range(4, 12);
    for (int c = 0; c < 3000; c++) begin
      bus.load_valid = ($urandom_range(0, 9) == 0);
      bus.load_value = 16'($urandom_range(0, 5));
      if (hold == 0) begin
        bus.start_btn = ~bus.start_btn;
        hold = $urandom_range(4, 12);
      end else begin
        hold--;
      end
      step(1);
      model_edge(bus.start_btn, bus.load_valid, int'(bus.load_value));
      if (bus.count_reg !== 16'(m_cnt) || bus.busy !== (m_mode == 1) || bus.done !== (m_mode == 2))
        chk_out($sformatf("rnd%0d", c), m_cnt, m_mode == 1, m_mode == 2);
      else
        checks++;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/countdown_fsm.md
Name: countdown_fsm

Overview:
- Programmable 16-bit down-counter FSM that produces `count_reg`.
- `count_reg` drives the `switches` input of the memory-mapped LED/switch read peripheral, so the CPU reads the live count over the bus.
- The CPU preloads the start value through a write strobe. A physical start button launches the countdown, which decrements once per prescaled tick and flags `done` at zero.

Parameters:
- COUNT_W, 16, width of the count value (matches the peripheral's 16-bit `switches` field).
- TICK_DIV, 100_000_000, clk cycles per decrement tick; must be >= 2.
- DB_CYCLES, 1_000_000, stable cycles required by the debouncer; used only when DEBOUNCE_EN is defined.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; asynchronous, active-high.
- load_value  input  COUNT_W  value to preload, from the CPU write data [15:0].
- load_valid  input  1  one-cycle write strobe, decoded from the CPU writeEnable plus address match.
- start_btn  input  1  raw, asynchronous push-button.
- count_reg  output  COUNT_W  current count; feeds the LED/switch peripheral.
- busy  output  1  high while in COUNT.
- done  output  1  high while in DONE.

Behaviour:
- Reset is asynchronous on `rst`. While asserted:
  - state = IDLE, count_reg = 0, busy = 0, done = 0.
  - Prescaler = 0, synchroniser flops = 0.
  - Reset mid-count aborts immediately; no tick or decrement completes.
- Button path:
  - start_btn passes through a 2-flop synchroniser (s1, s2), then a registered previous-value flop (s3).
  - start_pulse = s2 & ~s3, combinational, one cycle wide.
  - Latency: start_btn first sampled high at edge k gives busy = 1 after edge k+2.
- Prescaler:
  - tick_cnt counts 0..TICK_DIV-1 only in COUNT; it is held at 0 in every other state.
  - tick is asserted when tick_cnt == TICK_DIV-1; tick_cnt then wraps to 0.
- State machine (all outputs registered):
  - IDLE:
    - load_valid: count_reg <= load_value, stay in IDLE.
    - start_pulse with count_reg != 0: go to COUNT.
    - start_pulse with count_reg == 0: go to DONE.
    - load_valid and start_pulse in the same cycle: load wins and the start is dropped.
  - COUNT:
    - On tick: count_reg <= count_reg - 1.
    - If count_reg == 1 at that tick: count_reg <= 0 and go to DONE in the same edge.
    - start_pulse and load_valid are ignored.
    - No underflow is possible; count_reg never wraps below 0.
  - DONE:
    - count_reg holds 0.
    - load_valid: count_reg <= load_value and go to IDLE.
    - start_pulse is ignored.
- Output decode: busy = (state == COUNT), done = (state == DONE), both registered alongside the state.
- Total count duration from entering COUNT to entering DONE is exactly N*TICK_DIV cycles for load value N.
- load_value = 16'hFFFF is legal; it gives 65535 ticks.

Optional Feature:
- Macro name: DEBOUNCE_EN.
- Defined: between s2 and s3, a debounced level db replaces s2.
  - db toggles only after s2 has differed from db for DB_CYCLES consecutive cycles; a bounce resets the stability counter.
  - start_pulse = db & ~s3.
  - This adds DB_CYCLES cycles of latency; glitches shorter than DB_CYCLES produce no pulse.
- Undefined: no debounce logic is instantiated; behaviour is as described under Behaviour.

Decomposition:
- Package countdown_pkg:
  - state enum {IDLE, COUNT, DONE}, 2-bit encoding.
  - COUNT_W default constant.
- One sub-module, btn_conditioner:
  - Contains the synchroniser, the DEBOUNCE_EN debouncer and the edge detect.
  - Outputs start_pulse.
- countdown_fsm instantiates btn_conditioner and contains the prescaler and FSM.

Test Plan (TICK_DIV = 4, DB_CYCLES = 3):
- Reset/load: assert rst -> count_reg = 0, busy = 0, done = 0. Release, load_valid with load_value = 3 -> count_reg = 3 next edge; state stays IDLE.
- Countdown: after the load of 3, raise start_btn ->
  - busy = 1 two edges later;
  - count_reg steps 3→2→1→0 every 4 cycles;
  - done = 1 and busy = 0 exactly 12 cycles after busy rose.
- Zero start: load 0, press start -> done = 1 directly, busy never asserts.
- Collisions:
  - load_valid (value 5) in the same cycle as start_pulse in IDLE -> count_reg = 5, remains in IDLE.
  - load_valid during COUNT -> ignored, count continues.
- Abort/restart:
  - assert rst while count_reg = 2 in COUNT -> all outputs 0 immediately.
  - In DONE, load 7 -> IDLE with count_reg = 7; a start press while in DONE has no effect.
- DEBOUNCE_EN:
  - 2-cycle glitch on start_btn -> no busy.
  - 10-cycle press -> busy rises DB_CYCLES + 2 edges after first sample.
  - Without the macro, the same 2-cycle glitch starts the count.
